counter_request_arbiter: RTL and testbench
==========================================

Name: counter_request_arbiter

Overview:
- Parametrised successor to the fixed counter-cell priority logic: latches plus/minus increment pulses from N external sources (CDU, PIPA, gyro, etc.) into per-channel pending counts.
- Arbitrates pending channels and presents one registered request (counter address, direction) to the counter sequencer, which acknowledges each service.
- Adds beyond the fixed cell:
  - multi-deep pending counts with plus/minus cancellation;
  - sticky overflow flags;
  - selectable fixed-priority or round-robin arbitration.

Parameters:
- NCHAN, 8, number of counter channels (1..32).
- PEND_W, 2, width of per-direction pending count; max pending = 2**PEND_W-1.
- ADDR_W, 6, width of counter address output.
- BASE_ADDR, 6'o32, address of channel 0; channel i maps to BASE_ADDR+i.
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins), 1 = rotating priority.

Ports:
- CLOCK, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous reset, active low.
- inc_p, in, NCHAN, one-cycle plus-increment pulses, one bit per channel.
- inc_m, in, NCHAN, one-cycle minus-increment pulses, one bit per channel.
- svc_ack, in, 1, sequencer has serviced the currently presented request (one-cycle pulse).
- ovf_clr, in, NCHAN, clears the corresponding sticky overflow flags.
- req, out, 1, a counter request is presented.
- req_addr, out, ADDR_W, address of the requesting counter.
- req_minus, out, 1, 0 = plus increment, 1 = minus increment.
- req_chan, out, NCHAN, one-hot channel being presented.
- ovf, out, NCHAN, sticky per-channel pending-overflow flags.
- ack_err, out, 1, one-cycle pulse: svc_ack received while req=0.

Behaviour:
- Reset (rst low, asynchronous): all pending counts 0, ovf 0, req 0, req_addr 0, req_minus 0, req_chan 0, ack_err 0, round-robin pointer 0. Release is synchronous to the next CLOCK edge.
- Per-channel state: pcnt (PEND_W bits), mcnt (PEND_W bits). At most one of pcnt/mcnt is non-zero at any time.
- Input update at each edge, per channel. Net = inc_p - inc_m - (served direction if svc_ack hits this channel).
  - inc_p and inc_m both high: cancel, no change.
  - inc_p with mcnt>0: mcnt-1. Otherwise pcnt+1.
  - inc_m with pcnt>0: pcnt-1. Otherwise mcnt+1.
  - Increment on a count already at max: count holds at max, ovf[i] set. The pulse is lost.
  - ovf_clr[i] clears ovf[i]. If set and clear occur on the same edge, set wins.
  - svc_ack on the presented channel decrements the presented direction's count. It is applied together with same-edge increments in net form:
    - ack-decrement plus same-direction increment = no change;
    - ack-decrement at count 1 plus an opposite-direction increment = opposite count 1.
- Arbitration (combinational from pending state): eligible = pcnt>0 or mcnt>0.
  - Fixed mode: lowest eligible index wins.
  - Round-robin mode: first eligible index at or after the pointer, with wrap-around. The pointer becomes served index+1 (mod NCHAN) on each svc_ack.
- Outputs are registered:
  - Normally, at each edge, req/req_addr/req_minus/req_chan are loaded from the arbitration result of the post-update state.
  - Exception: on an edge where svc_ack=1 and req=1, req and req_chan are forced to 0 for one cycle (service bubble). This prevents double service; re-arbitration takes effect on the following edge.
  - While req=1 and no svc_ack, the presented channel/direction is held stable even if a higher-priority channel becomes eligible. The new winner is presented only after the next ack or bubble.
  - Exception: if the held request's pending count reaches 0 through cancellation, req drops at the next edge.
- Latency:
  - pulse in cycle k, idle arbiter: req=1 visible after edge k+1;
  - ack in cycle j: req=0 during cycle j+1; next request (if any) visible after edge j+2.
- ack_err: svc_ack while req=0 produces a one-cycle ack_err pulse. State is otherwise unchanged and the pointer does not move.
- Address: req_addr = BASE_ADDR + winning index, truncated to ADDR_W. It is 0 when req=0.

Decomposition:
- Shared package: counter direction enum (CNT_PLUS, CNT_MINUS), default BASE_ADDR constant, max-channel constant.
- Sub-module counter_cell: one channel's pcnt/mcnt saturating up/down logic, cancellation and ovf flag. Instantiated NCHAN times.
- Arbiter and output registers live in the top level.

Test Plan:
- Reset then single inc_p[3] pulse; ack two cycles after req rises.
  - Required: req=1, req_addr=6'o35, req_minus=0 after 1 edge.
  - After the ack: req=0 one cycle, then stays 0.
- inc_p[2] ×2 then inc_m[2] ×1.
  - Required: pcnt[2]=1 and one plus request. No minus request is ever presented.
- PEND_W=2: inc_m[5] ×4, no acks.
  - Required: mcnt=3 and ovf[5]=1.
  - ovf_clr[5] clears the flag.
  - Three acks produce three minus services, then req=0.
- Fixed mode: inc_p[1], inc_p[6] same cycle; ack each.
  - Required: channel 1 served first, then 6.
  - A pulse on channel 0 arriving while channel 6 is held does not pre-empt it.
- ROUND_ROBIN=1: channels 0 and 4 each hold pcnt=2; ack repeatedly.
  - Required: service order 0,4,0,4.
- Edge cases:
  - svc_ack with req=0 gives ack_err pulse, no state change.
  - rst asserted mid-request clears req immediately (asynchronously), all counts 0.

Source files
------------

// File: rtl/counter_request_arbiter_pkg.sv
// Shared types and constants for the counter request arbiter.
// Direction of a pending counter increment plus address/channel defaults.
package counter_request_arbiter_pkg;

   typedef enum logic {
      CNT_PLUS  = 1'b0,
      CNT_MINUS = 1'b1
   } cnt_dir_e;

   localparam logic [5:0] DEF_BASE_ADDR = 6'o32;
   localparam int         MAX_CHAN      = 32;

endpackage

// File: rtl/counter_request_arbiter_cell.sv
// One counter channel: signed pending count (plus side / minus side),
// saturating at 2**PEND_W-1 in either direction, with a sticky overflow flag.
module counter_cell
   import counter_request_arbiter_pkg::*;
#(
   parameter int PEND_W = 2
) (
   input  logic     CLOCK,
   input  logic     rst,
   input  logic     inc_p,
   input  logic     inc_m,
   input  logic     ack_hit,
   input  cnt_dir_e ack_dir,
   input  logic     ovf_clr,
   output logic     p_nz_nxt,
   output logic     m_nz_nxt,
   output logic     ovf
);

   localparam int CW = PEND_W + 2;
   localparam logic signed [CW-1:0] MAX_S  = CW'(2**PEND_W - 1);
   localparam logic signed [CW-1:0] ONE_S  = CW'(1);
   localparam logic signed [CW-1:0] ZERO_S = '0;

   logic [PEND_W-1:0]    pcnt, mcnt, pcnt_nxt, mcnt_nxt;
   logic signed [CW-1:0] cur, net, sum;
   logic                 sat;

   // Work on pcnt-mcnt as one signed value so cancellation and the
   // serviced direction fold into a single net adjustment.
   always_comb begin
      cur = $signed(CW'(pcnt)) - $signed(CW'(mcnt));
      net = $signed(CW'(inc_p)) - $signed(CW'(inc_m));
      if (ack_hit)
         net = (ack_dir == CNT_MINUS) ? net + ONE_S : net - ONE_S;
      sum = cur + net;
      sat = 1'b0;
      if (sum > MAX_S) begin
         sum = MAX_S;
         sat = 1'b1;
      end else if (sum < -MAX_S) begin
         sum = -MAX_S;
         sat = 1'b1;
      end
      pcnt_nxt = (sum > ZERO_S) ? PEND_W'(sum)  : '0;
      mcnt_nxt = (sum < ZERO_S) ? PEND_W'(-sum) : '0;
   end

   assign p_nz_nxt = |pcnt_nxt;
   assign m_nz_nxt = |mcnt_nxt;

   always_ff @(posedge CLOCK or negedge rst) begin
      if (!rst) begin
         pcnt <= '0;
         mcnt <= '0;
         ovf  <= 1'b0;
      end else begin
         pcnt <= pcnt_nxt;
         mcnt <= mcnt_nxt;
         ovf  <= sat | (ovf & ~ovf_clr);
      end
   end

endmodule

// File: rtl/counter_request_arbiter.sv
// Latches per-channel increment pulses into pending counts and presents one
// registered counter request at a time to the sequencer.
module counter_request_arbiter
   import counter_request_arbiter_pkg::*;
#(
   parameter int                NCHAN       = 8,
   parameter int                PEND_W      = 2,
   parameter int                ADDR_W      = 6,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
   parameter bit                ROUND_ROBIN = 1'b0
) (
   input  logic              CLOCK,
   input  logic              rst,
   input  logic [NCHAN-1:0]  inc_p,
   input  logic [NCHAN-1:0]  inc_m,
   input  logic              svc_ack,
   input  logic [NCHAN-1:0]  ovf_clr,
   output logic              req,
   output logic [ADDR_W-1:0] req_addr,
   output logic              req_minus,
   output logic [NCHAN-1:0]  req_chan,
   output logic [NCHAN-1:0]  ovf,
   output logic              ack_err
);

   localparam int IDX_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   logic [NCHAN-1:0] p_nz, m_nz, elig, ack_hit;
   logic [IDX_W-1:0] sel_idx, ptr, win_idx, n_idx, n_ptr;
   cnt_dir_e         req_dir, n_dir, win_dir;
   logic             win_vld, hold_ok, n_req;
   int               arb_base, arb_idx;

   assign ack_hit = (svc_ack && req) ? req_chan : '0;

   for (genvar i = 0; i < NCHAN; i++) begin : g_cell
      counter_cell #(.PEND_W(PEND_W)) u_cell (
         .CLOCK    (CLOCK),
         .rst      (rst),
         .inc_p    (inc_p[i]),
         .inc_m    (inc_m[i]),
         .ack_hit  (ack_hit[i]),
         .ack_dir  (req_dir),
         .ovf_clr  (ovf_clr[i]),
         .p_nz_nxt (p_nz[i]),
         .m_nz_nxt (m_nz[i]),
         .ovf      (ovf[i])
      );
   end

   // Arbitrate over the post-update pending state.
   assign elig = p_nz | m_nz;

   always_comb begin
      arb_base = ROUND_ROBIN ? int'(ptr) : 0;
      arb_idx  = 0;
      win_vld  = 1'b0;
      win_idx  = '0;
      for (int k = 0; k < NCHAN; k++) begin
         arb_idx = (arb_base + k) % NCHAN;
         if (!win_vld && elig[arb_idx]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(arb_idx);
         end
      end
      win_dir = m_nz[win_idx] ? CNT_MINUS : CNT_PLUS;
   end

   assign hold_ok = (req_dir == CNT_MINUS) ? m_nz[sel_idx] : p_nz[sel_idx];

   // A held request only changes on ack (bubble) or when cancellation
   // empties its count; new winners load only from the idle state.
   always_comb begin
      n_req = req;
      n_idx = sel_idx;
      n_dir = req_dir;
      n_ptr = ptr;
      if (svc_ack && req) begin
         n_req = 1'b0;
         n_dir = CNT_PLUS;
         if (ROUND_ROBIN)
            n_ptr = (sel_idx == IDX_W'(NCHAN-1)) ? '0 : sel_idx + 1'b1;
      end else if (req) begin
         if (!hold_ok) begin
            n_req = 1'b0;
            n_dir = CNT_PLUS;
         end
      end else begin
         n_req = win_vld;
         n_idx = win_idx;
         n_dir = win_vld ? win_dir : CNT_PLUS;
      end
   end

   always_ff @(posedge CLOCK or negedge rst) begin
      if (!rst) begin
         req      <= 1'b0;
         req_dir  <= CNT_PLUS;
         sel_idx  <= '0;
         ptr      <= '0;
         req_chan <= '0;
         req_addr <= '0;
         ack_err  <= 1'b0;
      end else begin
         req      <= n_req;
         req_dir  <= n_dir;
         sel_idx  <= n_idx;
         ptr      <= n_ptr;
         req_chan <= n_req ? (NCHAN'(1) << n_idx) : '0;
         req_addr <= n_req ? BASE_ADDR + ADDR_W'(n_idx) : '0;
         ack_err  <= svc_ack & ~req;
      end
   end

   assign req_minus = (req_dir == CNT_MINUS);

endmodule

// File: tb/tb_counter_request_arbiter.sv
// Drives a fixed-priority and a round-robin instance with shared increment
// stimulus; a queue-based scoreboard checks every cycle against a signed-count model.
module tb_counter_request_arbiter;

   localparam int         N    = 8;
   localparam int         MAXC = 3;
   localparam logic [5:0] BASE = 6'o32;

   typedef struct packed {
      logic         req;
      logic [5:0]   addr;
      logic         minus;
      logic [N-1:0] chan;
      logic [N-1:0] ovf;
      logic         ack_err;
   } obs_t;

   logic         CLOCK = 1'b0;
   logic         rst   = 1'b0;
   logic [N-1:0] inc_p = '0, inc_m = '0, ovf_clr = '0;
   logic         svc_ack [2];
   logic         req [2];
   logic [5:0]   req_addr [2];
   logic         req_minus [2];
   logic [N-1:0] req_chan [2];
   logic [N-1:0] ovf [2];
   logic         ack_err [2];

   always #5 CLOCK = ~CLOCK;

   counter_request_arbiter #(.NCHAN(N), .PEND_W(2), .ADDR_W(6), .BASE_ADDR(BASE), .ROUND_ROBIN(1'b0)) u_fix (
      .CLOCK(CLOCK), .rst(rst), .inc_p(inc_p), .inc_m(inc_m), .svc_ack(svc_ack[0]), .ovf_clr(ovf_clr),
      .req(req[0]), .req_addr(req_addr[0]), .req_minus(req_minus[0]), .req_chan(req_chan[0]),
      .ovf(ovf[0]), .ack_err(ack_err[0]));

   counter_request_arbiter #(.NCHAN(N), .PEND_W(2), .ADDR_W(6), .BASE_ADDR(BASE), .ROUND_ROBIN(1'b1)) u_rr (
      .CLOCK(CLOCK), .rst(rst), .inc_p(inc_p), .inc_m(inc_m), .svc_ack(svc_ack[1]), .ovf_clr(ovf_clr),
      .req(req[1]), .req_addr(req_addr[1]), .req_minus(req_minus[1]), .req_chan(req_chan[1]),
      .ovf(ovf[1]), .ack_err(ack_err[1]));

   int cmp_n = 0;
   int bad_n = 0;
   obs_t q0[$];
   obs_t q1[$];

   // Model: per channel a signed pending value (plus > 0, minus < 0).
   int           v [2][N];
   logic [N-1:0] m_ovf [2];
   bit           m_req [2];
   int           m_ch [2];
   bit           m_minus [2];
   int           m_ptr [2];

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      cmp_n++;
      if (a !== e) begin
         bad_n++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
      end
   endtask

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int ch = 0; ch < N; ch++) v[d][ch] = 0;
         m_ovf[d] = '0; m_req[d] = 0; m_ch[d] = 0; m_minus[d] = 0; m_ptr[d] = 0;
      end
   endfunction

   function automatic obs_t step(int d, logic [N-1:0] ip, logic [N-1:0] im, logic [N-1:0] clr, logic ack);
      obs_t o;
      int   net, nv, w, s;
      bit   sat;
      o = '0;
      o.ack_err = ack && !m_req[d];
      for (int ch = 0; ch < N; ch++) begin
         net = int'(ip[ch]) - int'(im[ch]);
         if (ack && m_req[d] && m_ch[d] == ch) net += m_minus[d] ? 1 : -1;
         nv  = v[d][ch] + net;
         sat = 0;
         if (nv > MAXC)  begin nv = MAXC;  sat = 1; end
         if (nv < -MAXC) begin nv = -MAXC; sat = 1; end
         v[d][ch] = nv;
         m_ovf[d][ch] = sat | (m_ovf[d][ch] & !clr[ch]);
      end
      if (ack && m_req[d]) begin
         if (d == 1) m_ptr[d] = (m_ch[d] + 1) % N;
         m_req[d] = 0;
      end else if (m_req[d]) begin
         if (m_minus[d] ? (v[d][m_ch[d]] >= 0) : (v[d][m_ch[d]] <= 0)) m_req[d] = 0;
      end else begin
         w = -1;
         s = (d == 1) ? m_ptr[d] : 0;
         for (int k = 0; k < N; k++)
            if (w < 0 && v[d][(s + k) % N] != 0) w = (s + k) % N;
         if (w >= 0) begin
            m_req[d] = 1; m_ch[d] = w; m_minus[d] = (v[d][w] < 0);
         end
      end
      o.req = m_req[d];
      if (m_req[d]) begin
         o.addr  = BASE + 6'(m_ch[d]);
         o.minus = m_minus[d];
         o.chan  = N'(1) << m_ch[d];
      end
      o.ovf = m_ovf[d];
      return o;
   endfunction

   function automatic obs_t act(int d);
      obs_t o;
      o.req = req[d]; o.addr = req_addr[d]; o.minus = req_minus[d];
      o.chan = req_chan[d]; o.ovf = ovf[d]; o.ack_err = ack_err[d];
      return o;
   endfunction

   // Monitor: pops the expected output for each edge that had stimulus.
   always @(posedge CLOCK) begin
      obs_t e;
      #1;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         chk("mon_fix", 32'(act(0)), 32'(e));
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         chk("mon_rr", 32'(act(1)), 32'(e));
      end
   end

   task automatic cyc(input logic [N-1:0] ip, input logic [N-1:0] im, input logic [N-1:0] clr,
                      input logic a0, input logic a1);
      @(negedge CLOCK);
      inc_p = ip; inc_m = im; ovf_clr = clr; svc_ack[0] = a0; svc_ack[1] = a1;
      q0.push_back(step(0, ip, im, clr, a0));
      q1.push_back(step(1, ip, im, clr, a1));
      @(posedge CLOCK);
      #2;
   endtask

   task automatic idle();
      cyc('0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic acks();
      cyc('0, '0, '0, m_req[0], m_req[1]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int exp_rr [4];
      exp_rr = '{0, 4, 0, 4};
      svc_ack[0] = 1'b0; svc_ack[1] = 1'b0;
      model_reset();
      #23;
      chk("rst_req",   32'(req[0]),      32'(0));
      chk("rst_chan",  32'(req_chan[0]), 32'(0));
      chk("rst_addr",  32'(req_addr[0]), 32'(0));
      chk("rst_ovf",   32'(ovf[1]),      32'(0));
      chk("rst_ackerr",32'(ack_err[1]),  32'(0));
      @(negedge CLOCK);
      rst = 1'b1;

      // single plus pulse on channel 3
      cyc(8'h08, '0, '0, 0, 0);
      chk("t1_req",   32'(req[0]),       32'(1));
      chk("t1_addr",  32'(req_addr[0]),  32'(6'o35));
      chk("t1_minus", 32'(req_minus[0]), 32'(0));
      idle();
      acks();
      chk("t1_bubble", 32'(req[0]), 32'(0));
      idle();
      chk("t1_done", 32'(req[0]), 32'(0));

      // plus/minus cancellation on channel 2
      cyc(8'h04, '0, '0, 0, 0);
      cyc(8'h04, '0, '0, 0, 0);
      cyc('0, 8'h04, '0, 0, 0);
      chk("t2_chan",  32'(req_chan[0]),  32'(8'h04));
      chk("t2_minus", 32'(req_minus[0]), 32'(0));
      acks();
      idle();
      chk("t2_done", 32'(req[0]), 32'(0));

      // minus saturation and sticky overflow on channel 5
      for (int k = 0; k < 4; k++) cyc('0, 8'h20, '0, 0, 0);
      chk("t3_ovf",   32'(ovf[0]),       32'(8'h20));
      chk("t3_minus", 32'(req_minus[0]), 32'(1));
      chk("t3_addr",  32'(req_addr[0]),  32'(6'o37));
      cyc('0, '0, 8'h20, 0, 0);
      chk("t3_ovfclr", 32'(ovf[0]), 32'(0));
      for (int k = 0; k < 3; k++) begin
         chk("t3_svc_minus", 32'({req[0], req_minus[0]}), 32'(2'b11));
         acks();
         chk("t3_bubble", 32'(req[0]), 32'(0));
         idle();
      end
      chk("t3_done", 32'(req[0]), 32'(0));

      // fixed priority and hold against a later higher-priority pulse
      cyc(8'h42, '0, '0, 0, 0);
      chk("t4_first", 32'(req_chan[0]), 32'(8'h02));
      acks();
      idle();
      chk("t4_second", 32'(req_chan[0]), 32'(8'h40));
      cyc(8'h01, '0, '0, 0, 0);
      chk("t4_hold", 32'(req_chan[0]), 32'(8'h40));
      acks();
      idle();
      chk("t4_third", 32'(req_chan[0]), 32'(8'h01));
      acks();
      idle();
      chk("t4_done", 32'(req[0]), 32'(0));

      // ack with nothing presented
      cyc('0, '0, '0, 1, 1);
      chk("ackerr_pulse", 32'({ack_err[0], ack_err[1]}), 32'(2'b11));
      chk("ackerr_noreq", 32'(req[0]), 32'(0));
      idle();
      chk("ackerr_clear", 32'({ack_err[0], ack_err[1]}), 32'(0));

      // asynchronous reset in the middle of a request
      cyc(8'h04, 8'h10, '0, 0, 0);
      chk("mid_req", 32'(req[0]), 32'(1));
      inc_p = '0; inc_m = '0; ovf_clr = '0; svc_ack[0] = 0; svc_ack[1] = 0;
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_req",  32'({req[0], req[1]}), 32'(0));
      chk("mid_rst_chan", 32'(req_chan[1]),      32'(0));
      model_reset();
      @(posedge CLOCK);
      @(negedge CLOCK);
      rst = 1'b1;
      idle();
      chk("mid_rst_empty", 32'({req[0], req[1]}), 32'(0));

      // round-robin alternation between channels 0 and 4
      cyc(8'h11, '0, '0, 0, 0);
      cyc(8'h11, '0, '0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         chk("rr_order", 32'(req_chan[1]), 32'(N'(1) << exp_rr[k]));
         acks();
         idle();
      end
      chk("rr_done", 32'(req[1]), 32'(0));

      // randomized traffic
      for (int it = 0; it < 600; it++) begin
         logic [N-1:0] ip, im, clr;
         logic a0, a1;
         ip  = N'($urandom & $urandom & $urandom);
         im  = N'($urandom & $urandom & $urandom);
         clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         a0  = m_req[0] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         a1  = m_req[1] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         cyc(ip, im, clr, a0, a1);
      end
      for (int k = 0; k < 3; k++) idle();
      chk("queue_drain", 32'(q0.size() + q1.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
      $finish;
   end

endmodule
